// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: "A<hex>" sets the address, "W<hex>E" writes, "R" reads.
// Each command raises o_stb until the bus acknowledges it.
module uart_cmd_decoder #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int AUTO_INC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_data_in,
  input  logic              i_data_valid,
  input  logic              i_ack,
  output logic              o_stb,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err,
  output logic [1:0]        o_dbg_state
);

  localparam int SR_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SR_W / 4 + 1) + 1;
  localparam logic [CNT_W-1:0] ADDR_DIGITS = CNT_W'(ADDR_W / 4);
  localparam logic [CNT_W-1:0] DATA_DIGITS = CNT_W'(DATA_W / 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    PEND  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic                prev_q, prev_d;

  logic       accept;
  logic [6:0] ch;
  logic       is_dec, is_alpha, is_hex;
  logic [3:0] nib;
  logic [SR_W-1:0] shifted;

  // Only the rising edge of the valid level delivers a byte.
  assign accept   = i_data_valid && !prev_q;
  assign ch       = i_data_in[6:0];
  assign is_dec   = (ch >= 7'h30) && (ch <= 7'h39);
  assign is_alpha = (ch >= 7'h61) && (ch <= 7'h66);
  assign is_hex   = is_dec || is_alpha;
  assign nib      = is_alpha ? (ch[3:0] + 4'd9) : ch[3:0];
  assign shifted  = (sr_q << 4) | SR_W'(nib);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    prev_d  = i_data_valid;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ch == 7'h41 || ch == 7'h57) begin
            state_d = (ch == 7'h41) ? ADDR : WDATA;
            sr_d    = '0;
            cnt_d   = '0;
          end else if (ch == 7'h52) begin
            state_d = PEND;
            wr_d    = 1'b0;
          end
        end
      end

      ADDR: begin
        if (accept) begin
          if (is_hex) begin
            if (cnt_q == ADDR_DIGITS) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              sr_d  = shifted;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if ((ch == 7'h45 || ch == 7'h57 || ch == 7'h52) && cnt_q != '0) begin
            addr_d = sr_q[ADDR_W-1:0];
            if (ch == 7'h45) begin
              state_d = IDLE;
            end else if (ch == 7'h57) begin
              state_d = WDATA;
              sr_d    = '0;
              cnt_d   = '0;
            end else begin
              state_d = PEND;
              wr_d    = 1'b0;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WDATA: begin
        if (accept) begin
          if (is_hex) begin
            if (cnt_q == DATA_DIGITS) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              sr_d  = shifted;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (ch == 7'h45 && cnt_q != '0) begin
            data_d  = sr_q[DATA_W-1:0];
            wr_d    = 1'b1;
            state_d = PEND;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      PEND: begin
        // A byte arriving here is dropped; the acknowledge is still honoured.
        if (accept) err_d = 1'b1;
        if (i_ack) begin
          state_d = IDLE;
          if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      prev_q  <= prev_d;
    end
  end

  assign o_stb       = (state_q == PEND);
  assign o_wr        = wr_q;
  assign o_addr      = addr_q;
  assign o_data      = data_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder at default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_cmd_decoder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_data_in = 8'h00;
  logic        i_data_valid = 1'b0;
  logic        i_ack = 1'b0;
  logic        o_stb, o_wr, o_err;
  logic [15:0] o_addr;
  logic [31:0] o_data;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int failures = 0;

  uart_cmd_decoder dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data_in    (i_data_in),
    .i_data_valid (i_data_valid),
    .i_ack        (i_ack),
    .o_stb        (o_stb),
    .o_wr         (o_wr),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_err        (o_err),
    .o_dbg_state  (o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  // One byte per call: valid high for one cycle, then low for one cycle.
  // Returns on the falling edge right after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_data_in    = b;
    i_data_valid = 1'b1;
    @(negedge i_clk);
    i_data_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_ack();
    @(negedge i_clk);
    i_ack = 1'b1;
    @(negedge i_clk);
    i_ack = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (o_stb !== 1'b0) begin failures++; $display("FAIL reset_stb: got %b want 0", o_stb); end
    checks++; if (o_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b want 0", o_wr); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", o_err); end
    checks++; if (o_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h want 0000", o_addr); end
    checks++; if (o_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 00000000", o_data); end
    checks++; if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", o_dbg_state); end
    i_rst = 1'b0;
    // Acknowledge and hex bytes in IDLE must do nothing.
    do_ack();
    send_byte("5");
    checks++; if (o_addr !== 16'h0000) begin failures++; $display("FAIL idle_ack_addr: got %h want 0000", o_addr); end
    checks++; if (o_err !== 1'b0 || o_dbg_state !== 2'd0) begin failures++; $display("FAIL idle_hex: got err=%b state=%0d want err=0 state=0", o_err, o_dbg_state); end
  endtask

  task automatic test_write();
    send_str("A1fWdeadbeefE");
    checks++; if (o_stb !== 1'b1 || o_wr !== 1'b1) begin failures++; $display("FAIL wr_stb: got stb=%b wr=%b want 1 1", o_stb, o_wr); end
    checks++; if (o_addr !== 16'h001f) begin failures++; $display("FAIL wr_addr: got %h want 001f", o_addr); end
    checks++; if (o_data !== 32'hdeadbeef) begin failures++; $display("FAIL wr_data: got %h want deadbeef", o_data); end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checks++; if (o_stb !== 1'b1) begin failures++; $display("FAIL wr_hold cycle %0d: got stb=%b want 1", i, o_stb); end
    end
    do_ack();
    checks++; if (o_stb !== 1'b0) begin failures++; $display("FAIL wr_ack_stb: got %b want 0", o_stb); end
    checks++; if (o_addr !== 16'h0020) begin failures++; $display("FAIL wr_ack_addr: got %h want 0020", o_addr); end
  endtask

  task automatic test_read();
    send_byte("R");
    checks++; if (o_stb !== 1'b1 || o_wr !== 1'b0) begin failures++; $display("FAIL rd_stb: got stb=%b wr=%b want 1 0", o_stb, o_wr); end
    checks++; if (o_addr !== 16'h0020) begin failures++; $display("FAIL rd_addr: got %h want 0020", o_addr); end
    do_ack();
    checks++; if (o_stb !== 1'b0 || o_addr !== 16'h0021) begin failures++; $display("FAIL rd_ack: got stb=%b addr=%h want 0 0021", o_stb, o_addr); end
  endtask

  task automatic test_wrap();
    send_str("AffffE");
    checks++; if (o_addr !== 16'hffff || o_stb !== 1'b0) begin failures++; $display("FAIL wrap_load: got addr=%h stb=%b want ffff 0", o_addr, o_stb); end
    send_byte("R");
    checks++; if (o_stb !== 1'b1 || o_wr !== 1'b0 || o_addr !== 16'hffff) begin failures++; $display("FAIL wrap_rd: got stb=%b wr=%b addr=%h want 1 0 ffff", o_stb, o_wr, o_addr); end
    do_ack();
    checks++; if (o_addr !== 16'h0000 || o_stb !== 1'b0) begin failures++; $display("FAIL wrap_inc: got addr=%h stb=%b want 0000 0", o_addr, o_stb); end
  endtask

  task automatic test_errors();
    send_str("A5E");
    checks++; if (o_addr !== 16'h0005) begin failures++; $display("FAIL short_addr: got %h want 0005", o_addr); end
    send_str("A1234");
    checks++; if (o_err !== 1'b0 || o_dbg_state !== 2'd1) begin failures++; $display("FAIL four_digits: got err=%b state=%0d want 0 1", o_err, o_dbg_state); end
    send_byte("5");
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL fifth_digit_err: got %b want 1", o_err); end
    checks++; if (o_dbg_state !== 2'd0 || o_addr !== 16'h0005) begin failures++; $display("FAIL fifth_digit_state: got state=%0d addr=%h want 0 0005", o_dbg_state, o_addr); end
    @(negedge i_clk);
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_pulse_width: got %b want 0", o_err); end
    send_byte("W");
    checks++; if (o_err !== 1'b0 || o_dbg_state !== 2'd2) begin failures++; $display("FAIL w_enter: got err=%b state=%0d want 0 2", o_err, o_dbg_state); end
    send_byte("E");
    checks++; if (o_err !== 1'b1 || o_stb !== 1'b0 || o_dbg_state !== 2'd0) begin failures++; $display("FAIL we_err: got err=%b stb=%b state=%0d want 1 0 0", o_err, o_stb, o_dbg_state); end
    checks++; if (o_data !== 32'hdeadbeef) begin failures++; $display("FAIL we_data: got %h want deadbeef", o_data); end
    send_byte("Z");
    checks++; if (o_err !== 1'b0 || o_dbg_state !== 2'd0) begin failures++; $display("FAIL idle_other: got err=%b state=%0d want 0 0", o_err, o_dbg_state); end
    send_str("AZ");
    checks++; if (o_err !== 1'b1 || o_addr !== 16'h0005) begin failures++; $display("FAIL addr_other: got err=%b addr=%h want 1 0005", o_err, o_addr); end
  endtask

  task automatic test_pend_byte();
    send_byte("R");
    checks++; if (o_stb !== 1'b1 || o_addr !== 16'h0005) begin failures++; $display("FAIL pend_rd: got stb=%b addr=%h want 1 0005", o_stb, o_addr); end
    send_byte("7");
    checks++; if (o_err !== 1'b1 || o_stb !== 1'b1) begin failures++; $display("FAIL pend_byte: got err=%b stb=%b want 1 1", o_err, o_stb); end
    checks++; if (o_data !== 32'hdeadbeef || o_wr !== 1'b0 || o_addr !== 16'h0005) begin failures++; $display("FAIL pend_stable: got data=%h wr=%b addr=%h want deadbeef 0 0005", o_data, o_wr, o_addr); end
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    checks++; if (o_stb !== 1'b0 || o_addr !== 16'h0000) begin failures++; $display("FAIL pend_reset: got stb=%b addr=%h want 0 0000", o_stb, o_addr); end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int  rises;
    logic stb_prev;
    rises    = 0;
    stb_prev = 1'b0;
    @(negedge i_clk);
    i_rst        = 1'b1;
    i_data_in    = "R";
    i_data_valid = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_stb !== 1'b1) begin failures++; $display("FAIL valid_after_reset: got stb=%b want 1", o_stb); end
    for (int i = 0; i < 4; i++) begin
      if (o_stb === 1'b1 && stb_prev === 1'b0) rises++;
      stb_prev = o_stb;
      @(negedge i_clk);
    end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL held_valid_err: got %b want 0", o_err); end
    i_data_valid = 1'b0;
    do_ack();
    for (int i = 0; i < 4; i++) begin
      if (o_stb === 1'b1 && stb_prev === 1'b0) rises++;
      stb_prev = o_stb;
      @(negedge i_clk);
    end
    checks++; if (rises != 1) begin failures++; $display("FAIL held_valid_txns: got %0d want 1", rises); end
    checks++; if (o_addr !== 16'h0001 || o_stb !== 1'b0) begin failures++; $display("FAIL held_valid_addr: got addr=%h stb=%b want 0001 0", o_addr, o_stb); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_errors();
    test_pend_byte();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
